// File: rtl/alu_muldiv_if.sv
// Issue/result bus between the execute-stage pipeline and the alu_muldiv unit.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic [2:0]       op;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op, start, flush, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  op, start, flush, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle MIPS-style MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Iterative shift-add multiply and restoring divide, one bit per cycle.
// Optional macro ALU_MULDIV_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         nrst,
    alu_muldiv_if.slave  bus
);
    localparam int unsigned W     = WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W-1:0]       hi_q, hi_d;
    logic [W-1:0]       lo_q, lo_d;
    logic [W-1:0]       acc_hi_q, acc_hi_d;   // product upper half / partial remainder
    logic [W-1:0]       acc_lo_q, acc_lo_d;   // multiplier bits / dividend-to-quotient
    logic [W-1:0]       opb_q, opb_d;         // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;         // product/quotient must be negated
    logic               neg_rem_q, neg_rem_d; // remainder takes dividend sign
    logic               div0_q, div0_d;

    logic               signed_op;
    logic               sa, sb;
    logic [W-1:0]       ma, mb;
    logic [W:0]         mul_sum;
    logic [W:0]         div_shift;
    logic [W:0]         div_trial;
    logic [2*W-1:0]     prod;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       quo_fix;
    logic [W-1:0]       rem_fix;

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic signed [W:0]     fast_a, fast_b;
    logic signed [2*W+1:0] fast_p;
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        // Operand magnitudes and sign flags for a new issue (ops 0 and 2 are signed)
        signed_op = ~bus.op[0];
        sa        = signed_op & bus.a[W-1];
        sb        = signed_op & bus.b[W-1];
        ma        = sa ? -bus.a : bus.a;
        mb        = sb ? -bus.b : bus.b;

        // One shift-add step: add multiplicand when the current multiplier bit is set
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        // One restoring-divide step: trial subtract of the divisor
        div_shift = {acc_hi_q, acc_lo_q[W-1]};
        div_trial = div_shift - {1'b0, opb_q};

        // Sign correction applied in FIX
        prod      = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -acc_lo_q : acc_lo_q;
        rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;

`ifdef ALU_MULDIV_FAST_MUL_EN
        fast_a    = $signed({sa, bus.a});
        fast_b    = $signed({sb, bus.b});
        fast_p    = fast_a * fast_b;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    unique case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d  = bus.op[1];
                            neg_d     = sa ^ sb;
                            neg_rem_d = sa;
                            div0_d    = (bus.b == '0);
                            acc_hi_d  = '0;
                            acc_lo_d  = bus.op[1] ? ma : mb;
                            opb_d     = bus.op[1] ? mb : ma;
                            cnt_d     = '0;
                            state_d   = RUN;
`ifdef ALU_MULDIV_FAST_MUL_EN
                            // Full signed product registered now; FIX only writes it out
                            if (!bus.op[1]) begin
                                {acc_hi_d, acc_lo_d} = fast_p[2*W-1:0];
                                neg_d                = 1'b0;
                                state_d              = FIX;
                            end
`endif
                        end
                        3'd4:    hi_d = bus.a;
                        3'd5:    lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], ~div_trial[W]};
                    end else begin
                        acc_hi_d = mul_sum[W:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = div0_q ? '1 : quo_fix;
                    end else begin
                        hi_d = prod_fix[2*W-1:W];
                        lo_d = prod_fix[W-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide unit that extends the combinational ALU with MIPS-style MULT/MULTU/DIV/DIVU and the HI/LO result registers. It sits beside the ALU in the execute stage. The pipeline issues an operation with a one-cycle start strobe and stalls on busy. Results are held in internal HI/LO registers until overwritten.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be even and ≥4.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the iteration counter; derived, never overridden.
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `nrst`, input, 1: reset, asynchronous assertion, active-low.
- `op`, input, 3: operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- `start`, input, 1: issue strobe, sampled only when `busy`=0.
- `flush`, input, 1: cancels an in-progress operation.
- `a`, input, WIDTH: multiplicand/dividend, or source for MTHI/MTLO.
- `b`, input, WIDTH: multiplier/divisor.
- `busy`, output, 1: an operation is in progress.
- `done`, output, 1: one-cycle pulse when HI/LO receive a MULT/DIV result.
- `hi`, output, WIDTH: HI register (product upper half, or remainder).
- `lo`, output, WIDTH: LO register (product lower half, or quotient).

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - RUN: one iteration per cycle.
  - FIX: sign correction and HI/LO write.
- IDLE transitions on `start`=1:
  - op 0–3: latch operands, go to RUN. Signed ops latch magnitudes plus result-sign flags.
  - op 4 (MTHI): `hi`←`a` at the same edge; stay IDLE, no `done`.
  - op 5 (MTLO): `lo`←`a` at the same edge; stay IDLE, no `done`.
  - op 6–7: ignored.
- `start` while `busy`=1 is ignored, including MTHI/MTLO.
- RUN:
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Counter runs WIDTH iterations, then goes to FIX.
- FIX:
  - Signed multiply: negate the 2·WIDTH product if operand signs differ.
  - Signed divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Results are modulo 2^WIDTH per half.
- Divide by zero, any sign: `lo`=all ones, `hi`=`a`.
- Signed overflow, most-negative ÷ −1: `lo`=most-negative, `hi`=0.
- `flush`=1 in RUN/FIX: return to IDLE next edge; `hi`/`lo` unchanged; no `done`. `flush` in IDLE has no effect. `flush` takes priority over a simultaneous FIX write.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM=IDLE, counter=0. An in-flight operation is discarded.
- Let E0 be the accepting edge and L the latency:
  - `busy`=1 from after E0 through the cycle before E(L).
  - `hi`/`lo` update at E(L).
  - `done`=1 for the single cycle after E(L); `busy`=0 in that same cycle.
- L = WIDTH+1 for the iterative paths (WIDTH RUN cycles plus one FIX cycle).
- A new `start` is accepted in the `done` cycle, giving back-to-back issue.
- MTHI/MTLO: zero busy cycles; the value is visible the cycle after the edge.
- `busy` and `done` are registered outputs; `hi`/`lo` come straight from their registers.

## Configuration
- `ALU_MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a combinational signed-extended WIDTH×WIDTH multiplier registered once, so L=1.
  - RUN and FIX are skipped for multiplies.
  - Divide is unchanged at L=WIDTH+1.
- Undefined: multiplies use the iterative shift-add path, L=WIDTH+1. No multiplier array is synthesised.

## Test plan
- All scenarios use WIDTH=32, macro undefined unless stated.
- MULT a=0xFFFFFFFD (−3), b=7 → `busy` high 33 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, one `done` pulse.
- MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. With the macro defined, the same result follows after exactly 1 busy cycle.
- DIVU 100/7 → `lo`=14, `hi`=2.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 5/0 → `lo`=0xFFFFFFFF, `hi`=5.
- DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTLO a=0x1234 while idle → `lo`=0x1234 next cycle, `busy` stays 0. Issue MTHI during a DIV → ignored.
- Start DIV:
  - `flush` at cycle 10 → `busy`=0 next cycle, `hi`/`lo` unchanged, no `done`.
  - Repeat with `nrst` pulsed low mid-RUN → all outputs 0 immediately.
  - Back-to-back `start` in the `done` cycle is accepted.
